// File: rtl/shl_seq.sv
// rtl/shl_seq.sv - sequential left shifter, one bit position per clock
//
// Purpose: shifts operand Desplazar left by Cantidad positions, one position
//          per clock, and reports the last bit that left the MSB on Acarreo.
//          FSM: IDLE -> SHIFT (Cantidad cycles) -> DONE (one cycle) -> IDLE.
//          A zero shift amount skips SHIFT and goes straight to DONE.
//
// Optional feature: define SHL_ROTATE_EN to rotate left instead of a
//          zero-fill logical shift. Latency and handshake are identical.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   operation request, sampled only in IDLE
//   Desplazar   in   [WIDTH-1:0] operand, captured on accepted start
//   Cantidad    in   [CNT_W-1:0] shift amount, captured with Desplazar
//   Desplazados out  [WIDTH-1:0] shift register (final result when done=1)
//   Acarreo     out  last bit shifted out of the MSB, 0 for Cantidad=0
//   busy        out  high in SHIFT and DONE
//   done        out  one-cycle completion pulse

module shl_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Desplazar,
    input  logic [CNT_W-1:0] Cantidad,
    output logic [WIDTH-1:0] Desplazados,
    output logic             Acarreo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Result registers hold their value in IDLE until a new
                // operation is accepted.
                if (start) begin
                    sh_d    = Desplazar;
                    cnt_d   = Cantidad;
                    carry_d = 1'b0;
                    state_d = (Cantidad == '0) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
`ifdef SHL_ROTATE_EN
                sh_d    = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
`else
                sh_d    = {sh_q[WIDTH-2:0], 1'b0};
`endif
                carry_d = sh_q[WIDTH-1];
                cnt_d   = cnt_q - CNT_W'(1);
                // The shift for count 1 is the final one; leave after it.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Desplazados = sh_q;
    assign Acarreo     = carry_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_shl_seq.sv
// tb/tb_shl_seq.sv - directed self-checking bench for shl_seq

module tb_shl_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

`ifdef SHL_ROTATE_EN
    localparam logic [7:0] EXP_81_1 = 8'h03;
    localparam logic [7:0] EXP_FF_7 = 8'hFF;
    localparam logic [7:0] EXP_2C_3 = 8'h61;
`else
    localparam logic [7:0] EXP_81_1 = 8'h02;
    localparam logic [7:0] EXP_FF_7 = 8'h80;
    localparam logic [7:0] EXP_2C_3 = 8'h60;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] desplazar;
    logic [CNT_W-1:0] cantidad;
    logic [WIDTH-1:0] desplazados;
    logic             acarreo;
    logic             busy;
    logic             done;

    int tests  = 0;
    int failed = 0;

    shl_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Desplazar  (desplazar),
        .Cantidad   (cantidad),
        .Desplazados(desplazados),
        .Acarreo    (acarreo),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One start pulse; measures latency and busy length, checks the result,
    // then checks that done drops and the block is idle again.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] c,
                          input logic [7:0] exp_res, input logic exp_c);
        int lat;
        int busy_n;
        desplazar = d;
        cantidad  = c;
        start     = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        if (busy) busy_n++;
        check8({tag, "_latency"}, 8'(lat), 8'(c) + 8'd1);
        check1({tag, "_done"}, done, 1'b1);
        check8({tag, "_result"}, desplazados, exp_res);
        check1({tag, "_carry"}, acarreo, exp_c);
        check8({tag, "_busy_cycles"}, 8'(busy_n), 8'(c) + 8'd1);
        step();
        check1({tag, "_done_pulse_end"}, done, 1'b0);
        check1({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        desplazar = 8'h00;
        cantidad  = 3'd0;
        step();
        step();
        check8("reset_result", desplazados, 8'h00);
        check1("reset_carry", acarreo, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);

        // Reset wins over a simultaneous start.
        start     = 1'b1;
        desplazar = 8'h55;
        cantidad  = 3'd2;
        step();
        check1("rst_prio_busy", busy, 1'b0);
        check8("rst_prio_result", desplazados, 8'h00);
        rst   = 1'b0;
        start = 1'b0;
        step();

        run_op("op_81_1", 8'h81, 3'd1, EXP_81_1, 1'b1);
        run_op("op_A5_0", 8'hA5, 3'd0, 8'hA5, 1'b0);
        run_op("op_FF_7", 8'hFF, 3'd7, EXP_FF_7, 1'b1);
        run_op("op_2C_3", 8'h2C, 3'd3, EXP_2C_3, 1'b1);

        // Outputs hold in IDLE while inputs move and start stays low.
        desplazar = 8'h3C;
        cantidad  = 3'd5;
        step();
        step();
        check8("idle_hold_result", desplazados, EXP_2C_3);
        check1("idle_hold_carry", acarreo, 1'b1);

        // Second start during SHIFT is ignored.
        desplazar = 8'h01;
        cantidad  = 3'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        desplazar = 8'hF0;
        cantidad  = 3'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        check1("ignore_done", done, 1'b1);
        check8("ignore_result", desplazados, 8'h08);
        check1("ignore_carry", acarreo, 1'b0);
        step();
        step();
        check1("ignore_no_requeue", busy, 1'b0);

        // Reset in the 2nd SHIFT cycle aborts without a done pulse.
        desplazar = 8'h0F;
        cantidad  = 3'd5;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        check8("abort_mid_value", desplazados, 8'h1E);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check8("abort_result", desplazados, 8'h00);
        check1("abort_carry", acarreo, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        begin
            logic seen_done;
            seen_done = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (done) seen_done = 1'b1;
            end
            check1("abort_no_done_later", seen_done, 1'b0);
        end
        run_op("op_0F_4", 8'h0F, 3'd4, 8'hF0, 1'b0);

        // start held high: done every 4 cycles with the same result.
        desplazar = 8'h03;
        cantidad  = 3'd2;
        start     = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check1($sformatf("held_done_k%0d", k), done, (k % 4) == 3);
            if (done) begin
                check8($sformatf("held_result_k%0d", k), desplazados, 8'h0C);
                check1($sformatf("held_carry_k%0d", k), acarreo, 1'b0);
            end
        end
        start = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/shl_seq.md
SHL_SEQ -- requirements
Module: shl_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width in bits (power of two, >= 2).
REQ-002 SHALL have parameter: CNT_W, 3, width of Cantidad, equal to log2(WIDTH).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port: Desplazar  input  WIDTH  operand, captured when start is accepted.
REQ-007 SHALL have port: Cantidad  input  CNT_W  shift amount 0..WIDTH-1, captured with Desplazar.
REQ-008 SHALL have port: Desplazados  output  WIDTH  registered shift result; valid while done=1, held until the next accepted start.
REQ-009 SHALL have port: Acarreo  output  1  last bit shifted out of the MSB; 0 when Cantidad=0.
REQ-010 SHALL have port: busy  output  1  high in SHIFT and DONE states.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE with start=1, load the shift register from Desplazar, the counter from Cantidad, clear Acarreo, and go to SHIFT; if Cantidad=0, go to DONE instead.
REQ-014 SHALL, in SHIFT, do one left shift per clock: register <= register<<1 with zero fill, Acarreo <= old MSB, counter decremented; when the counter reaches 1, the shift occurs and the FSM goes to DONE.
REQ-015 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-016 SHALL give a latency of Cantidad+1 cycles: start accepted at edge 0, done high in the cycle after edge max(Cantidad,0)+0 for Cantidad=0, and after edge Cantidad otherwise.
REQ-017 SHALL ignore start in SHIFT and DONE; no queuing. A start held high is accepted in the first IDLE cycle after done.
REQ-018 SHALL let Desplazados expose intermediate shift values while busy=1; consumers use it only when done=1 or in IDLE.
REQ-019 SHALL NOT change Desplazados or Acarreo in IDLE until a start is accepted.
REQ-020 SHALL produce Desplazados equal to (Desplazar << Cantidad) truncated to WIDTH bits, with Acarreo = Desplazar[WIDTH-Cantidad] when Cantidad>0.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, set state to IDLE and clear Desplazados, Acarreo, busy, done, and the counter, regardless of state.
REQ-022 SHALL give rst priority over start in the same cycle; the aborted operation produces no done pulse.

Configuration
REQ-023 SHALL, when macro SHL_ROTATE_EN is defined, rotate left in SHIFT: register <= {register[WIDTH-2:0], register[WIDTH-1]}. Acarreo still equals the bit that left the MSB, and latency and handshake are unchanged.
REQ-024 SHALL, without SHL_ROTATE_EN, perform a logical left shift with zero fill per REQ-014 and REQ-020.

Verification
REQ-025 SHALL cover: Desplazar=0x81, Cantidad=1, start pulse -> done 2 cycles after start, Desplazados=0x02, Acarreo=1; with SHL_ROTATE_EN, 0x03, Acarreo=1.
REQ-026 SHALL cover: Desplazar=0xA5, Cantidad=0 -> done in the cycle after start, Desplazados=0xA5, Acarreo=0, busy high for 1 cycle.
REQ-027 SHALL cover: Desplazar=0xFF, Cantidad=7 -> done 8 cycles after start, Desplazados=0x80, Acarreo=1; with SHL_ROTATE_EN, 0xFF, Acarreo=1.
REQ-028 SHALL cover: start with 0x01/Cantidad=3, then start with 0xF0/Cantidad=1 pulsed mid-SHIFT -> second request ignored, result 0x08, Acarreo=0.
REQ-029 SHALL cover: rst asserted during the 2nd SHIFT cycle of 0x0F/Cantidad=5 -> next cycle all outputs 0, state IDLE, no done; a following start of 0x0F/Cantidad=4 gives 0xF0, Acarreo=0.
REQ-030 SHALL cover: start held high continuously with 0x03/Cantidad=2 -> done pulses every 4 cycles (IDLE, SHIFT, SHIFT, DONE), each with Desplazados=0x0C.
